// File: rtl/loader_pkg.sv
// Shared types and helpers for the memory load/run/dump sequencer.
package loader_pkg;

  // Sequencer phase; encoding is fixed so it can be probed externally.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Highest address of a memory with aw address bits.
  function automatic int unsigned LAST_ADDR(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Selects which agent drives the single memory port, keyed by sequencer phase.
module mem_port_mux
  import loader_pkg::*;
#(
  parameter int unsigned addr_width = 8,
  parameter int unsigned data_width = 8
) (
  input  state_t                  state,
  input  logic                    load_write,
  input  logic [addr_width-1:0]   load_addr,
  input  logic [data_width-1:0]   load_wdata,
  input  logic [addr_width-1:0]   dump_addr,
  input  logic                    cpu_write,
  input  logic [addr_width-1:0]   cpu_addr,
  input  logic [data_width-1:0]   cpu_wdata,
  output logic                    mem_write,
  output logic [addr_width-1:0]   mem_addr,
  output logic [data_width-1:0]   mem_wdata
);

  // Loader writes in LOAD, CPU owns the port in RUN, dump reads in DUMP, idle in DONE.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      LOAD: begin
        mem_write = load_write;
        mem_addr  = load_addr;
        mem_wdata = load_write ? load_wdata : '0;
      end
      RUN: begin
        mem_write = cpu_write;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      DUMP: begin
        mem_addr  = dump_addr;
      end
      default: begin
        mem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_loader_dumper.sv
// Load/run/dump sequencer owning the memory port between a CPU and its memory.
// Optional CPU-initiated early stop is enabled by defining LOADER_HALT_EN.
module mem_loader_dumper
  import loader_pkg::*;
#(
  parameter int unsigned addr_width  = 8,
  parameter int unsigned data_width  = 8,
  parameter int unsigned count_width = 16,
  parameter int unsigned run_cycles  = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [data_width-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [addr_width-1:0]   out_addr,
  output logic [data_width-1:0]   out_data,
  output logic                    cpu_rst,
  input  logic                    cpu_write,
  input  logic [addr_width-1:0]   cpu_addr,
  input  logic [data_width-1:0]   cpu_wdata,
  output logic [data_width-1:0]   cpu_rdata,
  output logic                    mem_write,
  output logic [addr_width-1:0]   mem_addr,
  output logic [data_width-1:0]   mem_wdata,
  input  logic [data_width-1:0]   mem_rdata,
`ifdef LOADER_HALT_EN
  input  logic                    cpu_halt,
  output logic                    halted,
`endif
  output logic                    done
);

  state_t                  state;
  state_t                  state_nxt;
  logic [addr_width-1:0]   load_ptr;
  logic [addr_width-1:0]   dump_ptr;
  logic [count_width-1:0]  count;
  logic                    load_fire;
  logic                    dump_fire;
  logic                    load_last;
  logic                    dump_last;
  logic                    run_last;
  logic                    halt_req;

  // Transfer qualifiers; loads are suppressed while reset is held.
  assign load_fire = (state == LOAD) && in_valid && !rst;
  assign dump_fire = (state == DUMP) && out_ready;
  assign load_last = (load_ptr == addr_width'(LAST_ADDR(addr_width)));
  assign dump_last = (dump_ptr == addr_width'(LAST_ADDR(addr_width)));
  assign run_last  = (count == count_width'(run_cycles - 1));

`ifdef LOADER_HALT_EN
  assign halt_req = (state == RUN) && cpu_halt;
`else
  assign halt_req = 1'b0;
`endif

  // Handshake and status outputs depend only on the registered phase.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DUMP);
  assign cpu_rst   = (state != RUN);
  assign done      = (state == DONE);
  assign out_addr  = dump_ptr;
  assign out_data  = mem_rdata;
  assign cpu_rdata = mem_rdata;

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Phase sequencing: load all words, run for the budget (or until halt), dump all words.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (load_fire && load_last)  state_nxt = RUN;
      RUN:  if (run_last || halt_req)    state_nxt = DUMP;
      DUMP: if (dump_fire && dump_last)  state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  // Load/dump pointers wrap naturally at the top of memory; counter tracks RUN clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_ptr <= '0;
      dump_ptr <= '0;
      count    <= '0;
    end else begin
      if (load_fire)     load_ptr <= load_ptr + addr_width'(1);
      if (dump_fire)     dump_ptr <= dump_ptr + addr_width'(1);
      if (state == RUN)  count    <= count + count_width'(1);
    end
  end

`ifdef LOADER_HALT_EN
  // Sticky record that RUN ended on a CPU halt request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           halted <= 1'b0;
    else if (halt_req) halted <= 1'b1;
  end
`endif

  mem_port_mux #(
    .addr_width (addr_width),
    .data_width (data_width)
  ) u_mux (
    .state      (state),
    .load_write (load_fire),
    .load_addr  (load_ptr),
    .load_wdata (in_data),
    .dump_addr  (dump_ptr),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

endmodule

// File: tb/tb_mem_loader_dumper.sv
// Bench for mem_loader_dumper: behavioural memory, emulated CPU traffic, reference image.
module tb_mem_loader_dumper;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned RUNC  = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_addr, out_data;
  logic       cpu_rst, cpu_write;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       done;
`ifdef LOADER_HALT_EN
  logic       cpu_halt, halted;
`endif

  logic [7:0] mem     [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_loader_dumper #(
    .addr_width(8), .data_width(8), .count_width(16), .run_cycles(RUNC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .cpu_rst(cpu_rst), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef LOADER_HALT_EN
    .cpu_halt(cpu_halt), .halted(halted),
`endif
    .done(done)
  );

  // Behavioural single-port memory with combinational read.
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    cpu_write = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
`ifdef LOADER_HALT_EN
    cpu_halt = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Gap-free load of random words; leaves the bench at the first RUN cycle.
  task automatic do_load();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      ref_mem[i] = in_data;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got=%b want=1", cpu_rst); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL reset_out_addr got=%h want=00", out_addr); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h want=00", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got=%h want=00", mem_wdata); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
`ifdef LOADER_HALT_EN
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_with_gaps();
    int ptr = 0;
    int c = 0;
    int bad = 0;
    while (ptr < DEPTH && c < 1000) begin
      in_valid = (c % 3 != 2);
      in_data  = 8'(ptr);
      #1;
      checks++;
      if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
        errors++; $display("FAIL load_status ptr=%0d in_ready=%b cpu_rst=%b want 1/1", ptr, in_ready, cpu_rst);
      end
      checks++;
      if (mem_write !== in_valid) begin
        errors++; $display("FAIL load_mem_write ptr=%0d got=%b want=%b", ptr, mem_write, in_valid);
      end
      if (in_valid) begin
        checks++;
        if (mem_addr !== 8'(ptr) || mem_wdata !== 8'(ptr)) begin
          errors++; $display("FAIL load_port got addr=%h data=%h want %h/%h", mem_addr, mem_wdata, 8'(ptr), 8'(ptr));
        end
        ref_mem[ptr] = 8'(ptr);
        ptr++;
      end
      c++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++; if (ptr != DEPTH) begin errors++; $display("FAIL load_timeout got=%0d want=%0d", ptr, DEPTH); end
    checks++;
    if (cpu_rst !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL load_to_run cpu_rst=%b in_ready=%b want 0/0", cpu_rst, in_ready);
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL load_contents bad_words=%0d want=0", bad); end
  endtask

  task automatic test_cpu_run();
    int k = 0;
    int run_len = 0;
    while (k < 200) begin
      cpu_write = 1'b0;
      cpu_addr  = 8'($urandom);
      cpu_wdata = 8'($urandom);
      if (k == 3) begin
        cpu_write = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'h5A;
      end else if (k >= 7 && k <= 12) begin
        cpu_write = 1'b1;
        if (cpu_addr == 8'h80) cpu_addr = 8'h81;
      end
      #1;
      if (cpu_rst !== 1'b0) break;
      run_len++;
      checks++;
      if (mem_write !== cpu_write || mem_addr !== cpu_addr || mem_wdata !== cpu_wdata) begin
        errors++; $display("FAIL run_passthru got w=%b a=%h d=%h want w=%b a=%h d=%h",
                           mem_write, mem_addr, mem_wdata, cpu_write, cpu_addr, cpu_wdata);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || cpu_rdata !== mem_rdata) begin
        errors++; $display("FAIL run_status in_ready=%b out_valid=%b rdata=%h want 0/0/%h",
                           in_ready, out_valid, cpu_rdata, mem_rdata);
      end
      if (cpu_write) ref_mem[cpu_addr] = cpu_wdata;
      k++;
      @(negedge clk);
    end
    checks++; if (run_len != RUNC) begin errors++; $display("FAIL run_length got=%0d want=%0d", run_len, RUNC); end
  endtask

  task automatic test_dump_backpressure();
    logic [3:0] pat = 4'b1001;
    int idx = 0;
    int t = 0;
    while (idx < DEPTH && t < 4000) begin
      out_ready = pat[t % 4];
      cpu_write = 1'b1;
      cpu_addr  = 8'($urandom);
      cpu_wdata = 8'($urandom);
      #1;
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || mem_write !== 1'b0) begin
        errors++; $display("FAIL dump_status idx=%0d valid=%b done=%b cpu_rst=%b mem_write=%b want 1/0/1/0",
                           idx, out_valid, done, cpu_rst, mem_write);
      end
      checks++;
      if (out_addr !== 8'(idx) || out_data !== ref_mem[idx]) begin
        errors++; $display("FAIL dump_word got addr=%h data=%h want %h/%h", out_addr, out_data, 8'(idx), ref_mem[idx]);
      end
      if (idx == 8'h80) begin
        checks++;
        if (out_data !== 8'h5A) begin errors++; $display("FAIL dump_cpu_store got=%h want=5a", out_data); end
      end
      if (out_ready) idx++;
      t++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    checks++; if (idx != DEPTH) begin errors++; $display("FAIL dump_timeout got=%0d want=%0d", idx, DEPTH); end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL dump_done done=%b out_valid=%b in_ready=%b want 1/0/0", done, out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || mem_write !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++; $display("FAIL done_hold done=%b mem_write=%b cpu_rst=%b want 1/0/1", done, mem_write, cpu_rst);
    end
    cpu_write = 1'b0;
  endtask

  task automatic test_mid_run_reset();
    int bad = 0;
    apply_reset();
    do_load();
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL midrun_pre cycle=%0d cpu_rst=%b want=0", k, cpu_rst); end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b1 || out_valid !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL midrun_reset in_ready=%b cpu_rst=%b out_valid=%b mem_write=%b mem_addr=%h want 1/1/0/0/00",
                         in_ready, cpu_rst, out_valid, mem_write, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL midrun_retain bad_words=%0d want=0", bad); end
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    #1;
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL midrun_restart mem_write=%b mem_addr=%h want 1/00", mem_write, mem_addr);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef LOADER_HALT_EN
  task automatic test_halt();
    int hk_list [2] = '{5, 29};
    for (int h = 0; h < 2; h++) begin
      int k = 0;
      int run_len = 0;
      apply_reset();
      cpu_halt = 1'b1;
      do_load();
      cpu_halt = 1'b0;
      #1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_ignored_in_load got=%b want=0", halted); end
      while (k < 200) begin
        cpu_halt = (k == hk_list[h]);
        #1;
        if (cpu_rst !== 1'b0) break;
        run_len++;
        k++;
        @(negedge clk);
      end
      cpu_halt = 1'b0;
      checks++;
      if (run_len != hk_list[h] + 1) begin
        errors++; $display("FAIL halt_run_length got=%0d want=%0d", run_len, hk_list[h] + 1);
      end
      checks++;
      if (out_valid !== 1'b1 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_dump_entry out_valid=%b halted=%b want 1/1", out_valid, halted);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    test_reset();
    test_load_with_gaps();
    test_cpu_run();
    test_dump_backpressure();
    test_mid_run_reset();
`ifdef LOADER_HALT_EN
    test_halt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
